avr_io_intc: RTL and testbench
==============================

# avr_io_intc

Interrupt controller sitting directly upstream of the AVR core's interrupt inputs, replacing the combinational priority encoder. Peripheral IRQ lines (UART, timer, keypad, sound) are latched per line as edge- or level-sensitive, masked, and priority-encoded into registered `iflag`/`ivect`. An acknowledge from the core clears the serviced edge flag. Registers sit on the I/O bus; the top level decodes the block select.

## Interface
- `N_IRQ`, default 4: number of IRQ lines, 1..8.
- `VECT_W`, default 2: vector width; `2**VECT_W >= N_IRQ`.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `io_re` in 1: read strobe, already qualified by block select.
- `io_we` in 1: write strobe, already qualified by block select.
- `io_a` in 2: register address.
- `io_do` in 8: write data from the core.
- `io_di` out 8: read data onto the wired-OR bus; 0 when `io_re`=0.
- `irq_in` in N_IRQ: raw peripheral requests, active-high.
- `ack_stb` in 1: one-cycle pulse when the core accepts an interrupt.
- `ack_vect` in VECT_W: vector being acknowledged, valid with `ack_stb`.
- `iflag` out 1: registered; an enabled interrupt is pending.
- `ivect` out VECT_W: registered; highest-priority pending vector.

## Operation
- Registers, N_IRQ LSBs used; unused bits read 0:
  - addr 0 IFR: pending flags. Read gives flags. Write-1 clears edge-mode bits and has no effect on level-mode bits.
  - addr 1 IER: enable mask, read/write.
  - addr 2 ICR: mode per line; 1 = rising-edge latched, 0 = level.
  - addr 3 ISTAT: read gives `{iflag, 7-VECT_W zeros, ivect}`. Write-1 sets IFR bits of edge-mode lines (software trigger).
- Edge mode:
  - `prev[i]` holds last sampled `irq_in[i]`.
  - `irq_in & ~prev` sets IFR[i].
  - Cleared by IFR write-1, or by `ack_stb` with `ack_vect==i`.
- Level mode: IFR[i] = sampled `irq_in[i]` every cycle. Ack and W1C have no effect.
- Simultaneous set and clear on the same bit, from any sources: set wins; no event is lost.
- `ack_vect >= N_IRQ` is ignored.
- `act = IFR & IER`:
  - `iflag <= |act`.
  - `ivect <=` lowest index set in `act`, or 0 if none.
  - Index 0 has highest priority.
- Changing ICR from level to edge keeps the current IFR bit; it then follows edge rules.
- Reset, mid-operation included: IFR, IER, ICR, `prev`, synchronizers, `iflag`, `ivect` all go to 0. Pending events are discarded.

## Timing
- Register writes take effect at the `clk` edge where `io_we`=1.
- Reads are combinational from current state. A read in the same cycle as an update returns the pre-update value.
- Latency without sync:
  - `irq_in` rises before edge t, so IFR is set at edge t.
  - `iflag`/`ivect` are valid after edge t+1.
- Enabling an already-pending line via an IER write at edge t gives `iflag`=1 after edge t+1.
- `ack_stb` at edge t clears the flag at edge t. `iflag` drops after edge t+1 if nothing else is pending.
- Between ack and that drop, `ivect` may still show the acked vector for one cycle. The core must not re-sample inside this window.
- The core holds `ack_stb` for exactly one cycle. A multi-cycle ack clears repeatedly; this is harmless.

## Configuration
- `AVR_INTC_SYNC_EN` defined:
  - Each `irq_in` bit passes through a 2-flop synchronizer (reset 0) before edge/level logic.
  - Adds 2 cycles; `iflag` is valid after edge t+3.
  - Required when peripherals run on a different clock, such as the 100 MHz keypad or sound logic.
- Not defined: `irq_in` is sampled directly; the peripheral must be synchronous to `clk`.

## Structure
- Shared include `avr_io_intc_defs.vh`:
  - Register address constants `INTC_IFR`=0, `INTC_IER`=1, `INTC_ICR`=2, `INTC_ISTAT`=3.
  - ISTAT field positions.
  - Used by RTL, bench and firmware headers.
- Sub-module `intc_line`, one per IRQ line via generate:
  - Contains optional synchronizer, `prev` flop, and IFR bit set/clear logic.
  - Inputs: mode, w1c, swset, ack-hit.
  - Output: pending bit.
- Top level holds IER/ICR, the priority encoder, output registers and read mux.

## Test plan
- Reset: hold `rst_n`=0 with `irq_in`=4'hF → `iflag`=0, `ivect`=0, all registers read 0. Release → still 0 (IER=0).
- Priority: IER=4'hF, ICR=4'hF, pulse `irq_in`[3] and [1] together for 1 cycle → IFR=4'hA, `iflag`=1, `ivect`=1. Ack vect 1 → `ivect`=3. Ack vect 3 → `iflag`=0.
- Level mode: ICR=0, IER=4'h4, hold `irq_in`[2]=1 → `ivect`=2, `iflag`=1. Ack has no effect; W1C has no effect. Drop `irq_in`[2] → `iflag`=0 two cycles later.
- Collision: new edge on line 0 in the same cycle as ack vect 0 → IFR[0] stays 1, `iflag` stays 1.
- Masking/software: IER=0, write ISTAT=8'h02 with ICR=4'hF → IFR=4'h2, `iflag`=0. Write IER=4'h2 → `iflag`=1, `ivect`=1. Write IFR=8'h02 → `iflag`=0.
- Mid-operation reset with 2 pending: assert `rst_n`=0 asynchronously → outputs 0 immediately.
- Sync variant: with `AVR_INTC_SYNC_EN` defined, latency from `irq_in` to `iflag` measures exactly 4 edges.

Source files
------------

// File: rtl/avr_io_intc_pkg.sv
// Shared definitions for avr_io_intc: register addresses and ISTAT field positions.
// Imported by the RTL and the bench.
package avr_io_intc_pkg;

  localparam logic [1:0] INTC_IFR   = 2'd0;
  localparam logic [1:0] INTC_IER   = 2'd1;
  localparam logic [1:0] INTC_ICR   = 2'd2;
  localparam logic [1:0] INTC_ISTAT = 2'd3;

  localparam int unsigned ISTAT_FLAG_BIT = 7;
  localparam int unsigned ISTAT_VECT_LSB = 0;

endpackage

// File: rtl/avr_io_intc_line.sv
// One IRQ line: optional input synchronizer, edge detector and pending flag.
// Synchronizer present only when AVR_INTC_SYNC_EN is defined.
module intc_line (
  input  logic clk,
  input  logic rst_n,
  input  logic i_irq,
  input  logic i_mode,     // 1 = rising-edge latched, 0 = level
  input  logic i_w1c,
  input  logic i_swset,
  input  logic i_ack_hit,
  output logic o_pend
);

  logic w_irq;
  logic r_prev;
  logic r_pend;
  logic w_pend_d;
  logic w_set;
  logic w_clr;

`ifdef AVR_INTC_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_irq;
      r_sync2 <= r_sync1;
    end
  end

  assign w_irq = r_sync2;
`else
  assign w_irq = i_irq;
`endif

  assign w_set = (w_irq & ~r_prev) | i_swset;
  assign w_clr = i_w1c | i_ack_hit;

  // Set wins over any clear so a new event arriving with an ack is never lost.
  always_comb begin
    w_pend_d = r_pend;
    if (!i_mode) begin
      w_pend_d = w_irq;
    end else if (w_set) begin
      w_pend_d = 1'b1;
    end else if (w_clr) begin
      w_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      r_prev <= w_irq;
      r_pend <= w_pend_d;
    end
  end

  assign o_pend = r_pend;

endmodule

// File: rtl/avr_io_intc.sv
// AVR I/O-bus interrupt controller: per-line latching, mask, registered priority encode.
// Define AVR_INTC_SYNC_EN to add a 2-flop synchronizer on every irq_in bit.
module avr_io_intc
  import avr_io_intc_pkg::*;
#(
  parameter int unsigned N_IRQ  = 4,
  parameter int unsigned VECT_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              io_re,
  input  logic              io_we,
  input  logic [1:0]        io_a,
  input  logic [7:0]        io_do,
  output logic [7:0]        io_di,
  input  logic [N_IRQ-1:0]  irq_in,
  input  logic              ack_stb,
  input  logic [VECT_W-1:0] ack_vect,
  output logic              iflag,
  output logic [VECT_W-1:0] ivect
);

  logic [N_IRQ-1:0]  r_ier;
  logic [N_IRQ-1:0]  r_icr;
  logic              r_iflag;
  logic [VECT_W-1:0] r_ivect;

  logic [N_IRQ-1:0]  w_pend;
  logic [N_IRQ-1:0]  w_w1c;
  logic [N_IRQ-1:0]  w_swset;
  logic [N_IRQ-1:0]  w_ack_hit;
  logic [N_IRQ-1:0]  w_act;
  logic [VECT_W-1:0] w_vect;
  logic [7:0]        w_stat;
  logic              w_unused;

  assign w_unused = ^io_do;

  assign w_w1c   = (io_we && io_a == INTC_IFR)   ? io_do[N_IRQ-1:0] : '0;
  // Software trigger only reaches edge-mode lines.
  assign w_swset = (io_we && io_a == INTC_ISTAT) ? (io_do[N_IRQ-1:0] & r_icr) : '0;

  for (genvar i = 0; i < N_IRQ; i++) begin : g_line
    assign w_ack_hit[i] = ack_stb && (ack_vect == VECT_W'(i));

    intc_line u_line (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_irq     (irq_in[i]),
      .i_mode    (r_icr[i]),
      .i_w1c     (w_w1c[i]),
      .i_swset   (w_swset[i]),
      .i_ack_hit (w_ack_hit[i]),
      .o_pend    (w_pend[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ier <= '0;
      r_icr <= '0;
    end else if (io_we) begin
      if (io_a == INTC_IER) r_ier <= io_do[N_IRQ-1:0];
      if (io_a == INTC_ICR) r_icr <= io_do[N_IRQ-1:0];
    end
  end

  assign w_act = w_pend & r_ier;

  // Descending scan leaves the lowest set index, which has the highest priority.
  always_comb begin
    w_vect = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_act[i]) w_vect = VECT_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iflag <= 1'b0;
      r_ivect <= '0;
    end else begin
      r_iflag <= |w_act;
      r_ivect <= w_vect;
    end
  end

  always_comb begin
    w_stat = '0;
    w_stat[ISTAT_FLAG_BIT] = r_iflag;
    w_stat[ISTAT_VECT_LSB +: VECT_W] = r_ivect;
  end

  always_comb begin
    io_di = '0;
    if (io_re) begin
      case (io_a)
        INTC_IFR: io_di = 8'(w_pend);
        INTC_IER: io_di = 8'(r_ier);
        INTC_ICR: io_di = 8'(r_icr);
        default:  io_di = w_stat;
      endcase
    end
  end

  assign iflag = r_iflag;
  assign ivect = r_ivect;

endmodule

// File: tb/tb_avr_io_intc.sv
// Directed self-checking bench for avr_io_intc (4 lines, 2-bit vector).
// Latency expectation follows AVR_INTC_SYNC_EN.
module tb_avr_io_intc;
  import avr_io_intc_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       io_re;
  logic       io_we;
  logic [1:0] io_a;
  logic [7:0] io_do;
  logic [7:0] io_di;
  logic [3:0] irq_in;
  logic       ack_stb;
  logic [1:0] ack_vect;
  logic       iflag;
  logic [1:0] ivect;

  int checks = 0;
  int errors = 0;

  avr_io_intc #(
    .N_IRQ  (4),
    .VECT_W (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .io_re    (io_re),
    .io_we    (io_we),
    .io_a     (io_a),
    .io_do    (io_do),
    .io_di    (io_di),
    .irq_in   (irq_in),
    .ack_stb  (ack_stb),
    .ack_vect (ack_vect),
    .iflag    (iflag),
    .ivect    (ivect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    io_we = 1'b1;
    io_a  = a;
    io_do = d;
    tick();
    io_we = 1'b0;
    io_do = 8'h00;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    io_re = 1'b1;
    io_a  = a;
    #1;
    d = io_di;
    io_re = 1'b0;
  endtask

  task automatic do_ack(input logic [1:0] v);
    ack_stb  = 1'b1;
    ack_vect = v;
    tick();
    ack_stb  = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst_n  = 1'b0;
    irq_in = 4'hF;
    repeat (3) tick();
    checks++;
    if (iflag !== 1'b0 || ivect !== 2'd0) begin
      errors++;
      $display("FAIL reset_out: got iflag=%b ivect=%0d, want 0 0", iflag, ivect);
    end
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      checks++;
      if (d !== 8'h00) begin
        errors++;
        $display("FAIL reset_reg%0d: got %h, want 00", a, d);
      end
    end
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (iflag !== 1'b0 || ivect !== 2'd0) begin
      errors++;
      $display("FAIL reset_release: got iflag=%b ivect=%0d, want 0 0", iflag, ivect);
    end
    // Lines default to level mode, so IFR mirrors the held requests.
    rd(INTC_IFR, d);
    checks++;
    if (d !== 8'h0F) begin
      errors++;
      $display("FAIL reset_level_ifr: got %h, want 0f", d);
    end
    irq_in = 4'h0;
    repeat (2) tick();
  endtask

  task automatic test_priority();
    logic [7:0] d;
    wr(INTC_IER, 8'h0F);
    wr(INTC_ICR, 8'h0F);
    irq_in = 4'hA;
    tick();
    irq_in = 4'h0;
    rd(INTC_IFR, d);
    checks++;
    if (d !== 8'h0A) begin
      errors++;
      $display("FAIL prio_ifr: got %h, want 0a", d);
    end
    tick();
    checks++;
    if (iflag !== 1'b1 || ivect !== 2'd1) begin
      errors++;
      $display("FAIL prio_first: got iflag=%b ivect=%0d, want 1 1", iflag, ivect);
    end
    do_ack(2'd1);
    tick();
    checks++;
    if (iflag !== 1'b1 || ivect !== 2'd3) begin
      errors++;
      $display("FAIL prio_second: got iflag=%b ivect=%0d, want 1 3", iflag, ivect);
    end
    do_ack(2'd3);
    tick();
    checks++;
    if (iflag !== 1'b0 || ivect !== 2'd0) begin
      errors++;
      $display("FAIL prio_drained: got iflag=%b ivect=%0d, want 0 0", iflag, ivect);
    end
  endtask

  task automatic test_level();
    logic [7:0] d;
    wr(INTC_ICR, 8'h00);
    wr(INTC_IER, 8'h04);
    irq_in = 4'h4;
    repeat (2) tick();
    checks++;
    if (iflag !== 1'b1 || ivect !== 2'd2) begin
      errors++;
      $display("FAIL level_assert: got iflag=%b ivect=%0d, want 1 2", iflag, ivect);
    end
    do_ack(2'd2);
    wr(INTC_IFR, 8'h04);
    tick();
    rd(INTC_IFR, d);
    checks++;
    if (iflag !== 1'b1 || d !== 8'h04) begin
      errors++;
      $display("FAIL level_noclear: got iflag=%b ifr=%h, want 1 04", iflag, d);
    end
    irq_in = 4'h0;
    tick();
    checks++;
    if (iflag !== 1'b1) begin
      errors++;
      $display("FAIL level_drop1: got iflag=%b, want 1", iflag);
    end
    tick();
    checks++;
    if (iflag !== 1'b0) begin
      errors++;
      $display("FAIL level_drop2: got iflag=%b, want 0", iflag);
    end
  endtask

  task automatic test_collision();
    logic [7:0] d;
    wr(INTC_ICR, 8'h0F);
    wr(INTC_IER, 8'h0F);
    irq_in = 4'h1;
    tick();
    irq_in = 4'h0;
    repeat (2) tick();
    checks++;
    if (iflag !== 1'b1 || ivect !== 2'd0) begin
      errors++;
      $display("FAIL coll_pre: got iflag=%b ivect=%0d, want 1 0", iflag, ivect);
    end
    irq_in = 4'h1;
    do_ack(2'd0);
    irq_in = 4'h0;
    rd(INTC_IFR, d);
    checks++;
    if (d !== 8'h01) begin
      errors++;
      $display("FAIL coll_ifr: got %h, want 01", d);
    end
    tick();
    checks++;
    if (iflag !== 1'b1 || ivect !== 2'd0) begin
      errors++;
      $display("FAIL coll_flag: got iflag=%b ivect=%0d, want 1 0", iflag, ivect);
    end
    wr(INTC_IFR, 8'h0F);
    tick();
    checks++;
    if (iflag !== 1'b0) begin
      errors++;
      $display("FAIL coll_w1c: got iflag=%b, want 0", iflag);
    end
  endtask

  task automatic test_software();
    logic [7:0] d;
    wr(INTC_IER, 8'h00);
    wr(INTC_ISTAT, 8'h02);
    rd(INTC_IFR, d);
    checks++;
    if (d !== 8'h02) begin
      errors++;
      $display("FAIL sw_ifr: got %h, want 02", d);
    end
    tick();
    checks++;
    if (iflag !== 1'b0) begin
      errors++;
      $display("FAIL sw_masked: got iflag=%b, want 0", iflag);
    end
    wr(INTC_IER, 8'h02);
    tick();
    rd(INTC_ISTAT, d);
    checks++;
    if (iflag !== 1'b1 || ivect !== 2'd1 || d !== 8'h81) begin
      errors++;
      $display("FAIL sw_enable: got iflag=%b ivect=%0d istat=%h, want 1 1 81", iflag, ivect, d);
    end
    wr(INTC_IFR, 8'h02);
    tick();
    checks++;
    if (iflag !== 1'b0) begin
      errors++;
      $display("FAIL sw_w1c: got iflag=%b, want 0", iflag);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] d;
    wr(INTC_IER, 8'h0F);
    wr(INTC_ISTAT, 8'h05);
    tick();
    checks++;
    if (iflag !== 1'b1 || ivect !== 2'd0) begin
      errors++;
      $display("FAIL mid_pre: got iflag=%b ivect=%0d, want 1 0", iflag, ivect);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (iflag !== 1'b0 || ivect !== 2'd0) begin
      errors++;
      $display("FAIL mid_async: got iflag=%b ivect=%0d, want 0 0", iflag, ivect);
    end
    rd(INTC_IFR, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL mid_ifr: got %h, want 00", d);
    end
    tick();
    rst_n = 1'b1;
    tick();
    rd(INTC_IER, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL mid_ier: got %h, want 00", d);
    end
  endtask

  task automatic test_latency();
    int n;
    int want;
`ifdef AVR_INTC_SYNC_EN
    want = 4;
`else
    want = 2;
`endif
    wr(INTC_ICR, 8'h0F);
    wr(INTC_IER, 8'h0F);
    repeat (3) tick();
    irq_in = 4'h4;
    n = 0;
    while (iflag !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (n !== want || ivect !== 2'd2) begin
      errors++;
      $display("FAIL latency: got %0d edges ivect=%0d, want %0d edges ivect=2", n, ivect, want);
    end
    irq_in = 4'h0;
    wr(INTC_IFR, 8'h0F);
    repeat (2) tick();
  endtask

  initial begin
    rst_n    = 1'b0;
    io_re    = 1'b0;
    io_we    = 1'b0;
    io_a     = 2'd0;
    io_do    = 8'h00;
    irq_in   = 4'h0;
    ack_stb  = 1'b0;
    ack_vect = 2'd0;
    #1;
    test_reset();
    test_priority();
    test_level();
    test_collision();
    test_software();
    test_mid_reset();
    test_latency();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
